gowin_pll_ctrl: RTL and testbench

Sequencing controller for the GW5A `PLL` primitive, placed between the board reference clock and the PLL instance. Holds and releases PLL reset and waits for a debounced lock. Gates up to seven output clock enables. Retries on lock timeout and re-locks after lock loss. Accepts runtime charge-pump and loop-filter settings over a valid/ready port. Drives the primitive's dynamic `ICPSEL`/`LPFRES`/`LPFCAP` and `ENCLKn` pins.

---
 rtl/gowin_pll_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_gowin_pll_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/gowin_pll_ctrl.sv
// Sequencing controller for the GW5A PLL: reset/lock/stabilise/run with retry,
// lock-loss recovery, runtime loop-filter settings and gated output enables.
module gowin_pll_ctrl #(
  parameter int          NUM_OUT            = 2,
  parameter int          RESET_CYCLES       = 16,
  parameter int          LOCK_TIMEOUT       = 65535,
  parameter int          LOCK_STABLE_CYCLES = 1024,
  parameter int          MAX_RETRIES        = 4,
  parameter logic [5:0]  ICP_DEFAULT        = 6'd16,
  parameter logic [2:0]  LPFRES_DEFAULT     = 3'd2,
  parameter logic [1:0]  LPFCAP_DEFAULT     = 2'd0
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic               pll_lock_i,
  output logic               pll_reset_o,
  output logic [5:0]         icpsel_o,
  output logic [2:0]         lpfres_o,
  output logic [1:0]         lpfcap_o,
  input  logic [NUM_OUT-1:0] en_req_i,
  output logic [NUM_OUT-1:0] enclk_o,
  input  logic               cfg_valid_i,
  input  logic [5:0]         cfg_icp_i,
  input  logic [2:0]         cfg_lpfres_i,
  input  logic [1:0]         cfg_lpfcap_i,
  output logic               cfg_ready_o,
  input  logic               relock_req_i,
  output logic               locked_o,
  output logic               fail_o,
  output logic [7:0]         retry_cnt_o,
  output logic [7:0]         lost_cnt_o
);

  localparam int CNT_MAX0 = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX  = (CNT_MAX0 > LOCK_STABLE_CYCLES) ? CNT_MAX0 : LOCK_STABLE_CYCLES;
  localparam int CW       = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STAB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [7:0]    RETRY_MAX = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {S_RST, S_WAIT, S_STAB, S_RUN, S_FAIL} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [7:0]          retry_q, retry_d, lost_q, lost_d;
  logic [5:0]          icp_q, icp_d;
  logic [2:0]          res_q, res_d;
  logic [1:0]          cap_q, cap_d;
  logic                lock_meta_q, lock_s_q;
  logic                pll_reset_q, pll_reset_d, locked_q, locked_d;
  logic                fail_q, fail_d, ready_q, ready_d;
  logic [NUM_OUT-1:0]  enclk_q, enclk_d;
  logic                accept_s;

  // Acceptance is qualified by the registered ready, so only RUN/FAIL can take a setting.
  assign accept_s = cfg_valid_i & ready_q;

  // Next-state, counters, loop settings and registered-output precompute.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    icp_d   = icp_q;
    res_d   = res_q;
    cap_d   = cap_q;
    case (state_q)
      S_RST: begin
        if (cnt_q >= RST_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT: begin
        // The cycle lock_s is first seen already counts as one stable cycle.
        if (lock_s_q) begin
          cnt_d = CNT_ONE;
          if (LOCK_STABLE_CYCLES == 1) begin
            state_d = S_RUN;
            retry_d = 8'd0;
          end else begin
            state_d = S_STAB;
          end
        end else if (cnt_q >= TO_LAST) begin
          cnt_d   = '0;
          retry_d = retry_q + 8'd1;
          state_d = ((retry_q + 8'd1) == RETRY_MAX) ? S_FAIL : S_RST;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STAB: begin
        if (!lock_s_q) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (cnt_q >= STAB_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
          retry_d = 8'd0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RUN: begin
        if (!lock_s_q && (lost_q != 8'hFF)) begin
          lost_d = lost_q + 8'd1;
        end else begin
          lost_d = lost_q;
        end
        // Config, relock and lock loss all collapse into a single RST entry.
        if (accept_s || relock_req_i || !lock_s_q) begin
          state_d = S_RST;
          cnt_d   = '0;
        end else begin
          state_d = S_RUN;
        end
        if (accept_s || relock_req_i) begin
          retry_d = 8'd0;
        end else begin
          retry_d = retry_q;
        end
        if (accept_s) begin
          icp_d = cfg_icp_i;
          res_d = cfg_lpfres_i;
          cap_d = cfg_lpfcap_i;
        end else begin
          icp_d = icp_q;
        end
      end
      S_FAIL: begin
        if (accept_s || relock_req_i) begin
          state_d = S_RST;
          cnt_d   = '0;
          retry_d = 8'd0;
        end else begin
          state_d = S_FAIL;
        end
        if (accept_s) begin
          icp_d = cfg_icp_i;
          res_d = cfg_lpfres_i;
          cap_d = cfg_lpfcap_i;
        end else begin
          icp_d = icp_q;
        end
      end
      default: begin
        state_d = S_RST;
        cnt_d   = '0;
      end
    endcase

    pll_reset_d = (state_d == S_RST) || (state_d == S_FAIL);
    locked_d    = (state_d == S_RUN);
    fail_d      = (state_d == S_FAIL);
    ready_d     = (state_d == S_RUN) || (state_d == S_FAIL);
    enclk_d     = ((state_q == S_RUN) && (state_d == S_RUN)) ? en_req_i : '0;
  end

  // State, counters, lock synchroniser and all outputs.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q     <= S_RST;
      cnt_q       <= '0;
      retry_q     <= 8'd0;
      lost_q      <= 8'd0;
      icp_q       <= ICP_DEFAULT;
      res_q       <= LPFRES_DEFAULT;
      cap_q       <= LPFCAP_DEFAULT;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      pll_reset_q <= 1'b1;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      ready_q     <= 1'b0;
      enclk_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      icp_q       <= icp_d;
      res_q       <= res_d;
      cap_q       <= cap_d;
      lock_meta_q <= pll_lock_i;
      lock_s_q    <= lock_meta_q;
      pll_reset_q <= pll_reset_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
      ready_q     <= ready_d;
      enclk_q     <= enclk_d;
    end
  end

  assign pll_reset_o = pll_reset_q;
  assign icpsel_o    = icp_q;
  assign lpfres_o    = res_q;
  assign lpfcap_o    = cap_q;
  assign enclk_o     = enclk_q;
  assign cfg_ready_o = ready_q;
  assign locked_o    = locked_q;
  assign fail_o      = fail_q;
  assign retry_cnt_o = retry_q;
  assign lost_cnt_o  = lost_q;

endmodule

// File: tb/tb_gowin_pll_ctrl.sv
// Directed, table-driven bench for gowin_pll_ctrl with hand-written corner sequences.
module tb_gowin_pll_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       lock;
  logic [1:0] en;
  logic       cv;
  logic [5:0] icp;
  logic [2:0] res;
  logic [1:0] cap;
  logic       relock;
  logic       pll_reset, cfg_ready, locked, fail;
  logic [5:0] icpsel;
  logic [2:0] lpfres;
  logic [1:0] lpfcap, enclk;
  logic [7:0] retry_cnt, lost_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gowin_pll_ctrl #(
    .NUM_OUT(2), .RESET_CYCLES(4), .LOCK_TIMEOUT(20),
    .LOCK_STABLE_CYCLES(8), .MAX_RETRIES(3)
  ) dut (
    .clkin(clk), .reset(rst), .pll_lock_i(lock), .pll_reset_o(pll_reset),
    .icpsel_o(icpsel), .lpfres_o(lpfres), .lpfcap_o(lpfcap),
    .en_req_i(en), .enclk_o(enclk), .cfg_valid_i(cv), .cfg_icp_i(icp),
    .cfg_lpfres_i(res), .cfg_lpfcap_i(cap), .cfg_ready_o(cfg_ready),
    .relock_req_i(relock), .locked_o(locked), .fail_o(fail),
    .retry_cnt_o(retry_cnt), .lost_cnt_o(lost_cnt)
  );

  typedef struct packed {
    logic       lock;
    logic [1:0] en;
    logic       cv;
    logic [5:0] icp;
    logic [2:0] res;
    logic [1:0] cap;
    logic       rl;
    logic [7:0] n;
    logic       e_rst;
    logic       e_lck;
    logic       e_fail;
    logic [1:0] e_en;
    logic       e_rdy;
    logic [5:0] e_icp;
    logic [2:0] e_res;
    logic [1:0] e_cap;
    logic [7:0] e_retry;
    logic [7:0] e_lost;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_rst, input logic e_lck,
                         input logic e_fail, input logic [1:0] e_en, input logic e_rdy,
                         input logic [5:0] e_icp, input logic [2:0] e_res,
                         input logic [1:0] e_cap, input logic [7:0] e_retry,
                         input logic [7:0] e_lost);
    chk({tag, " pll_reset"}, {7'd0, pll_reset}, {7'd0, e_rst});
    chk({tag, " locked"},    {7'd0, locked},    {7'd0, e_lck});
    chk({tag, " fail"},      {7'd0, fail},      {7'd0, e_fail});
    chk({tag, " enclk"},     {6'd0, enclk},     {6'd0, e_en});
    chk({tag, " ready"},     {7'd0, cfg_ready}, {7'd0, e_rdy});
    chk({tag, " icp"},       {2'd0, icpsel},    {2'd0, e_icp});
    chk({tag, " lpfres"},    {5'd0, lpfres},    {5'd0, e_res});
    chk({tag, " lpfcap"},    {6'd0, lpfcap},    {6'd0, e_cap});
    chk({tag, " retry"},     retry_cnt,         e_retry);
    chk({tag, " lost"},      lost_cnt,          e_lost);
  endtask

  task automatic add(input logic l, input logic [1:0] e, input logic v, input logic [5:0] ci,
                     input logic [2:0] cr, input logic [1:0] cc, input logic r, input int n,
                     input logic x_rst, input logic x_lck, input logic x_fail,
                     input logic [1:0] x_en, input logic x_rdy, input logic [5:0] x_icp,
                     input logic [2:0] x_res, input logic [1:0] x_cap,
                     input logic [7:0] x_retry, input logic [7:0] x_lost);
    vec_t t;
    t = '{l, e, v, ci, cr, cc, r, 8'(n), x_rst, x_lck, x_fail, x_en, x_rdy,
          x_icp, x_res, x_cap, x_retry, x_lost};
    tbl.push_back(t);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    lock = 1'b0; en = 2'b11; cv = 1'b0; icp = 6'd0; res = 3'd0; cap = 2'd0; relock = 1'b0;
  endtask

  // After return the bench sits in cycle 0: the next rising edge is the first one out of reset.
  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    //  lk en  cv icp   res   cap   rl  n | rst lck fl en    rdy icp    res   cap   retry lost
    add(0, 2'b11, 0, 6'd0, 3'd0, 2'd0, 0, 0,  1, 0, 0, 2'b00, 0, 6'd16, 3'd2, 2'd0, 8'd0, 8'd0); // c0
    add(0, 2'b11, 0, 6'd0, 3'd0, 2'd0, 0, 3,  1, 0, 0, 2'b00, 0, 6'd16, 3'd2, 2'd0, 8'd0, 8'd0); // c3
    add(0, 2'b11, 0, 6'd0, 3'd0, 2'd0, 0, 1,  0, 0, 0, 2'b00, 0, 6'd16, 3'd2, 2'd0, 8'd0, 8'd0); // c4
    add(0, 2'b11, 0, 6'd0, 3'd0, 2'd0, 0, 6,  0, 0, 0, 2'b00, 0, 6'd16, 3'd2, 2'd0, 8'd0, 8'd0); // c10
    add(1, 2'b11, 0, 6'd0, 3'd0, 2'd0, 0, 9,  0, 0, 0, 2'b00, 0, 6'd16, 3'd2, 2'd0, 8'd0, 8'd0); // c19
    add(1, 2'b11, 0, 6'd0, 3'd0, 2'd0, 0, 1,  0, 1, 0, 2'b00, 1, 6'd16, 3'd2, 2'd0, 8'd0, 8'd0); // c20
    add(1, 2'b11, 0, 6'd0, 3'd0, 2'd0, 0, 1,  0, 1, 0, 2'b11, 1, 6'd16, 3'd2, 2'd0, 8'd0, 8'd0); // c21
    add(1, 2'b11, 1, 6'd40, 3'd5, 2'd1, 0, 1, 1, 0, 0, 2'b00, 0, 6'd40, 3'd5, 2'd1, 8'd0, 8'd0); // c22
    add(1, 2'b11, 0, 6'd0, 3'd0, 2'd0, 0, 3,  1, 0, 0, 2'b00, 0, 6'd40, 3'd5, 2'd1, 8'd0, 8'd0); // c25
    add(1, 2'b11, 1, 6'd7, 3'd1, 2'd3, 0, 1,  0, 0, 0, 2'b00, 0, 6'd40, 3'd5, 2'd1, 8'd0, 8'd0); // c26
    add(1, 2'b11, 1, 6'd7, 3'd1, 2'd3, 0, 1,  0, 0, 0, 2'b00, 0, 6'd40, 3'd5, 2'd1, 8'd0, 8'd0); // c27
    add(1, 2'b11, 0, 6'd0, 3'd0, 2'd0, 0, 6,  0, 0, 0, 2'b00, 0, 6'd40, 3'd5, 2'd1, 8'd0, 8'd0); // c33
    add(1, 2'b11, 0, 6'd0, 3'd0, 2'd0, 0, 1,  0, 1, 0, 2'b00, 1, 6'd40, 3'd5, 2'd1, 8'd0, 8'd0); // c34
    add(1, 2'b11, 0, 6'd0, 3'd0, 2'd0, 0, 1,  0, 1, 0, 2'b11, 1, 6'd40, 3'd5, 2'd1, 8'd0, 8'd0); // c35
    add(0, 2'b11, 0, 6'd0, 3'd0, 2'd0, 0, 2,  0, 1, 0, 2'b11, 1, 6'd40, 3'd5, 2'd1, 8'd0, 8'd0); // c37
    add(0, 2'b11, 0, 6'd0, 3'd0, 2'd0, 0, 1,  1, 0, 0, 2'b00, 0, 6'd40, 3'd5, 2'd1, 8'd0, 8'd1); // c38
    add(0, 2'b11, 0, 6'd0, 3'd0, 2'd0, 0, 6,  0, 0, 0, 2'b00, 0, 6'd40, 3'd5, 2'd1, 8'd0, 8'd1); // c44
    add(1, 2'b11, 0, 6'd0, 3'd0, 2'd0, 0, 9,  0, 0, 0, 2'b00, 0, 6'd40, 3'd5, 2'd1, 8'd0, 8'd1); // c53
    add(1, 2'b11, 0, 6'd0, 3'd0, 2'd0, 0, 1,  0, 1, 0, 2'b00, 1, 6'd40, 3'd5, 2'd1, 8'd0, 8'd1); // c54
    add(1, 2'b01, 0, 6'd0, 3'd0, 2'd0, 0, 1,  0, 1, 0, 2'b01, 1, 6'd40, 3'd5, 2'd1, 8'd0, 8'd1); // c55
    add(1, 2'b10, 0, 6'd0, 3'd0, 2'd0, 0, 1,  0, 1, 0, 2'b10, 1, 6'd40, 3'd5, 2'd1, 8'd0, 8'd1); // c56
    add(1, 2'b10, 1, 6'd9, 3'd3, 2'd2, 1, 1,  1, 0, 0, 2'b00, 0, 6'd9,  3'd3, 2'd2, 8'd0, 8'd1); // c57
    add(1, 2'b10, 0, 6'd0, 3'd0, 2'd0, 0, 3,  1, 0, 0, 2'b00, 0, 6'd9,  3'd3, 2'd2, 8'd0, 8'd1); // c60
    add(1, 2'b10, 0, 6'd0, 3'd0, 2'd0, 0, 1,  0, 0, 0, 2'b00, 0, 6'd9,  3'd3, 2'd2, 8'd0, 8'd1); // c61
    add(1, 2'b10, 0, 6'd0, 3'd0, 2'd0, 0, 7,  0, 0, 0, 2'b00, 0, 6'd9,  3'd3, 2'd2, 8'd0, 8'd1); // c68
    add(1, 2'b10, 0, 6'd0, 3'd0, 2'd0, 0, 1,  0, 1, 0, 2'b00, 1, 6'd9,  3'd3, 2'd2, 8'd0, 8'd1); // c69
    add(0, 2'b10, 0, 6'd0, 3'd0, 2'd0, 0, 2,  0, 1, 0, 2'b10, 1, 6'd9,  3'd3, 2'd2, 8'd0, 8'd1); // c71
    add(0, 2'b10, 1, 6'd50, 3'd6, 2'd3, 0, 1, 1, 0, 0, 2'b00, 0, 6'd50, 3'd6, 2'd3, 8'd0, 8'd2); // c72
    add(0, 2'b10, 0, 6'd0, 3'd0, 2'd0, 0, 3,  1, 0, 0, 2'b00, 0, 6'd50, 3'd6, 2'd3, 8'd0, 8'd2); // c75
    add(0, 2'b10, 0, 6'd0, 3'd0, 2'd0, 0, 1,  0, 0, 0, 2'b00, 0, 6'd50, 3'd6, 2'd3, 8'd0, 8'd2); // c76

    apply_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      lock = tbl[i].lock; en = tbl[i].en; cv = tbl[i].cv;
      icp = tbl[i].icp; res = tbl[i].res; cap = tbl[i].cap; relock = tbl[i].rl;
      step(int'(tbl[i].n));
      chk_all($sformatf("v%0d", i), tbl[i].e_rst, tbl[i].e_lck, tbl[i].e_fail, tbl[i].e_en,
              tbl[i].e_rdy, tbl[i].e_icp, tbl[i].e_res, tbl[i].e_cap, tbl[i].e_retry,
              tbl[i].e_lost);
    end

    // Async reset in the middle of STAB, with non-default loop settings and lost count.
    lock = 1'b1;
    step(6);
    chk("pre_ar locked", {7'd0, locked}, 8'd0);
    chk("pre_ar pll_reset", {7'd0, pll_reset}, 8'd0);
    chk("pre_ar icp", {2'd0, icpsel}, 8'd50);
    #3 rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 6'd16, 3'd2, 2'd0, 8'd0, 8'd0);

    // Lock glitch during STAB: 5 stable cycles then a drop, then a full re-count.
    apply_reset();
    step(10);
    lock = 1'b1;
    step(5);
    lock = 1'b0;
    step(3);
    chk("glitch c18 locked", {7'd0, locked}, 8'd0);
    chk("glitch c18 pll_reset", {7'd0, pll_reset}, 8'd0);
    lock = 1'b1;
    step(2);
    chk("glitch c20 locked", {7'd0, locked}, 8'd0);
    step(7);
    chk("glitch c27 locked", {7'd0, locked}, 8'd0);
    step(1);
    chk("glitch c28 locked", {7'd0, locked}, 8'd1);

    // Never lock: three attempts then FAIL, then relock recovery.
    apply_reset();
    step(23);
    chk("nl c23 pll_reset", {7'd0, pll_reset}, 8'd0);
    chk("nl c23 retry", retry_cnt, 8'd0);
    step(1);
    chk("nl c24 pll_reset", {7'd0, pll_reset}, 8'd1);
    chk("nl c24 retry", retry_cnt, 8'd1);
    step(23);
    chk("nl c47 pll_reset", {7'd0, pll_reset}, 8'd0);
    step(1);
    chk("nl c48 retry", retry_cnt, 8'd2);
    step(23);
    chk("nl c71 fail", {7'd0, fail}, 8'd0);
    step(1);
    chk_all("nl c72", 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 6'd16, 3'd2, 2'd0, 8'd3, 8'd0);
    step(8);
    chk("nl c80 fail", {7'd0, fail}, 8'd1);
    chk("nl c80 pll_reset", {7'd0, pll_reset}, 8'd1);
    relock = 1'b1;
    step(1);
    relock = 1'b0;
    chk_all("relock c81", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 6'd16, 3'd2, 2'd0, 8'd0, 8'd0);
    step(3);
    chk("relock c84 pll_reset", {7'd0, pll_reset}, 8'd1);
    step(1);
    chk("relock c85 pll_reset", {7'd0, pll_reset}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
